shake_arbiter: RTL and testbench

- Shares one sponge core (SHAKE absorb/squeeze engine) between NUM_REQ requesters, e.g. ExpandA, ExpandS and SampleInBall units.
- Grants exclusive ownership per job, round-robin.
- Resets the core before each job, then muxes the owner's absorb stream into the core and routes squeezed words back to the owner only.

---
 rtl/shake_arb_pkg.sv | 9 +
 rtl/shake_rr_pick.sv | 26 ++
 rtl/shake_arbiter.sv | 145 ++++++++++++++
 tb/tb_shake_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_arb_pkg.sv
// shake_arb_pkg: shared types and constants for the sponge-core arbiter.
package shake_arb_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, WAIT, BUSY} state_e;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/shake_rr_pick.sv
// shake_rr_pick: combinational round-robin pick of the first request at or after ptr.
module shake_rr_pick
  import shake_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               any
);
  // Scan downward so the lowest distance from ptr is the last (winning) assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        idx = IW'((int'(ptr) + i) % NUM_REQ);
        any = 1'b1;
      end
    end
    onehot = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/shake_arbiter.sv
// shake_arbiter: round-robin per-job ownership of one SHAKE sponge core.
// Optional watchdog on an idle owner with SHAKE_ARB_TIMEOUT_EN.
module shake_arbiter
  import shake_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_IN_BITS = 64,
  parameter int DATA_OUT_BITS = 64,
  parameter int LEN_W = $clog2(DATA_IN_BITS) + 1,
  parameter int RST_CYCLES = DEF_RST_CYCLES
`ifdef SHAKE_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              rel,
  output logic [NUM_REQ-1:0]              grant,
  input  logic [NUM_REQ*DATA_IN_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*LEN_W-1:0]        req_last_len,
  output logic [NUM_REQ-1:0]              req_in_ready,
  input  logic [NUM_REQ-1:0]              req_out_ready,
  output logic [DATA_OUT_BITS-1:0]        rsp_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic                            core_rst,
  output logic                            core_cache_rst,
  output logic [DATA_IN_BITS-1:0]         core_data_in,
  output logic                            core_in_valid,
  output logic                            core_in_last,
  output logic [LEN_W-1:0]                core_last_len,
  input  logic                            core_in_ready,
  output logic                            core_out_ready,
  input  logic [DATA_OUT_BITS-1:0]        core_data_out,
  input  logic                            core_out_valid
`ifdef SHAKE_ARB_TIMEOUT_EN
  , output logic                          err_timeout
`endif
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(RST_CYCLES + 1);

  state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick_oh;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, pick_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic pick_any, busy, in_open, release_now, tmo_hit;

  shake_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign busy           = state_q == BUSY;
  assign in_open        = busy & core_in_ready & ~done_q;
  assign grant          = grant_q;
  assign core_rst       = (state_q == IDLE) | (state_q == CLEAR);
  assign core_cache_rst = core_rst;
  assign core_data_in   = busy ? req_data[int'(owner_q)*DATA_IN_BITS +: DATA_IN_BITS] : '0;
  assign core_last_len  = busy ? req_last_len[int'(owner_q)*LEN_W +: LEN_W] : '0;
  assign core_in_last   = busy & req_last[owner_q];
  assign core_in_valid  = in_open & req_valid[owner_q];
  assign req_in_ready   = in_open ? grant_q : '0;
  assign core_out_ready = busy & req_out_ready[owner_q];
  assign rsp_valid      = (busy & core_out_valid) ? grant_q : '0;
  assign rsp_data       = busy ? core_data_out : '0;
  assign release_now    = busy & (rel[owner_q] | tmo_hit);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    done_d  = done_q | (core_in_valid & core_in_last);
    case (state_q)
      IDLE: if (pick_any) begin
        state_d = CLEAR;
        grant_d = pick_oh;
        owner_d = pick_idx;
        cnt_d   = '0;
        done_d  = 1'b0;
      end
      CLEAR: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(RST_CYCLES - 1)) ? WAIT : CLEAR;
      end
      WAIT: state_d = BUSY;
      BUSY: if (release_now) begin
        state_d = IDLE;
        grant_d = '0;
        rr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef SHAKE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, hs;
  // Any absorb or squeeze handshake by the owner proves it is still alive.
  assign hs      = core_in_valid | (core_out_valid & core_out_ready);
  assign tmo_hit = busy & ~hs & (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;
  always_comb begin
    tmo_d = (busy & ~hs & ~tmo_hit) ? tmo_q + TW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif
endmodule

// File: tb/tb_shake_arbiter.sv
// tb_shake_arbiter: vector table, corner sequences and a randomized model check.
module tb_shake_arbiter;
  localparam int N = 4, DI = 64, DO = 64, LW = 7, RST = 2;
`ifdef SHAKE_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req, rel, grant, req_valid, req_last, req_in_ready, req_out_ready, rsp_valid;
  logic [N*DI-1:0] req_data;
  logic [N*LW-1:0] req_last_len;
  logic [DO-1:0] rsp_data, core_data_out;
  logic [DI-1:0] core_data_in;
  logic [LW-1:0] core_last_len;
  logic core_rst, core_cache_rst, core_in_valid, core_in_last, core_in_ready;
  logic core_out_ready, core_out_valid;
`ifdef SHAKE_ARB_TIMEOUT_EN
  logic err_timeout;
`endif

  always #5 clk = ~clk;

  shake_arbiter #(
    .NUM_REQ(N), .DATA_IN_BITS(DI), .DATA_OUT_BITS(DO), .LEN_W(LW), .RST_CYCLES(RST)
`ifdef SHAKE_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .grant(grant),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_last_len(req_last_len), .req_in_ready(req_in_ready),
    .req_out_ready(req_out_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .core_rst(core_rst), .core_cache_rst(core_cache_rst), .core_data_in(core_data_in),
    .core_in_valid(core_in_valid), .core_in_last(core_in_last),
    .core_last_len(core_last_len), .core_in_ready(core_in_ready),
    .core_out_ready(core_out_ready), .core_data_out(core_data_out),
    .core_out_valid(core_out_valid)
`ifdef SHAKE_ARB_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  int n_chk = 0, n_err = 0;
  int m_own, m_age, m_rr, m_idle;
  bit m_done, m_err;

  typedef struct {
    logic [N-1:0] req, rel, vld, lst;
    logic cir, cov;
    logic [N-1:0] ordy, e_grant;
    logic e_rst;
    logic [N-1:0] e_irdy;
    logic e_civ;
    logic [N-1:0] e_rspv;
    logic e_cor;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    req = '0; rel = '0; req_valid = '0; req_last = '0; req_data = '0; req_last_len = '0;
    req_out_ready = '0; core_in_ready = 1'b0; core_data_out = '0; core_out_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_core_rst", {core_rst, core_cache_rst}, 2'b11);
    chk("rst_in_ready", req_in_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_core_in_valid", core_in_valid, 0);
    chk("rst_core_out_ready", core_out_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Job-level model: owner index, age since grant, absorb-finished flag.
  task automatic model_step();
    bit busy, civ, hs, found;
    int w;
    busy = m_own >= 0 && m_age >= RST + 2;
    m_err = 1'b0;
    if (m_own < 0) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        w = (m_rr + i) % N;
        if (!found && req[w]) begin
          found = 1'b1; m_own = w; m_age = 1; m_done = 1'b0; m_idle = 0;
        end
      end
    end else if (busy) begin
      civ = req_valid[m_own] && core_in_ready && !m_done;
      hs = civ || (core_out_valid && req_out_ready[m_own]);
      m_idle = hs ? 0 : m_idle + 1;
      if (TMO > 0 && m_idle >= TMO) m_err = 1'b1;
      if (rel[m_own] || m_err) begin
        m_rr = (m_own + 1) % N;
        m_own = -1;
      end else if (civ && req_last[m_own]) m_done = 1'b1;
    end else m_age++;
  endtask

  task automatic check_model();
    bit busy;
    int o;
    logic [N-1:0] oh;
    busy = m_own >= 0 && m_age >= RST + 2;
    o = (m_own < 0) ? 0 : m_own;
    oh = (m_own < 0) ? '0 : N'(1) << o;
    chk("grant", grant, oh);
    chk("core_rst", core_rst, m_own < 0 || m_age <= RST);
    chk("core_cache_rst", core_cache_rst, m_own < 0 || m_age <= RST);
    chk("in_ready", req_in_ready, (busy && core_in_ready && !m_done) ? oh : '0);
    chk("core_in_valid", core_in_valid, busy && core_in_ready && !m_done && req_valid[o]);
    chk("rsp_valid", rsp_valid, (busy && core_out_valid) ? oh : '0);
    chk("rsp_data", rsp_data, busy ? core_data_out : '0);
    chk("core_out_ready", core_out_ready, busy && req_out_ready[o]);
    if (busy) begin
      chk("core_data_in", core_data_in, req_data[o*DI +: DI]);
      chk("core_in_last", core_in_last, req_last[o]);
      chk("core_last_len", core_last_len, req_last_len[o*LW +: LW]);
    end
`ifdef SHAKE_ARB_TIMEOUT_EN
    chk("err_timeout", err_timeout, m_err);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //          req      rel      vld      lst     cir  cov  ordy     grant   rst  irdy     civ  rspv     cor
    tv[0]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tv[1]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tv[2]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tv[3]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tv[4]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0};
    tv[5]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tv[6]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0};
    tv[7]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tv[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1};
    tv[9]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1};
    tv[10] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1};
    tv[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tv[12] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tv[13] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};

    do_reset();
    req_last_len = (N*LW)'(8) << LW;
    for (int i = 0; i < 14; i++) begin
      req = tv[i].req; rel = tv[i].rel; req_valid = tv[i].vld; req_last = tv[i].lst;
      core_in_ready = tv[i].cir; core_out_valid = tv[i].cov; req_out_ready = tv[i].ordy;
      @(negedge clk);
      chk($sformatf("tv%0d_grant", i), grant, tv[i].e_grant);
      chk($sformatf("tv%0d_core_rst", i), core_rst, tv[i].e_rst);
      chk($sformatf("tv%0d_in_ready", i), req_in_ready, tv[i].e_irdy);
      chk($sformatf("tv%0d_core_in_valid", i), core_in_valid, tv[i].e_civ);
      chk($sformatf("tv%0d_rsp_valid", i), rsp_valid, tv[i].e_rspv);
      chk($sformatf("tv%0d_core_out_ready", i), core_out_ready, tv[i].e_cor);
      if (tv[i].e_civ && tv[i].lst[1]) chk("tv_last_len", core_last_len, 8);
      @(posedge clk);
      #1;
    end

    // Contention: everyone requesting, each owner leaves after one squeeze word.
    do_reset();
    req = '1; req_out_ready = '1; core_out_valid = 1'b1; core_data_out = 64'h1234;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (grant == '0 && w < 10) begin @(negedge clk); w++; end
      chk("cont_grant", grant, 4'b1 << (k % 4));
      w = 0;
      while (rsp_valid == '0 && w < 10) begin @(negedge clk); w++; end
      chk("cont_rsp_valid", rsp_valid, 4'b1 << (k % 4));
      @(posedge clk); #1 rel = 4'b1 << (k % 4);
      @(posedge clk); #1 rel = '0;
    end

    // Asynchronous reset between clock edges while BUSY.
    do_reset();
    req = 4'b0001; core_out_valid = 1'b1; req_out_ready = '1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ar_busy_core_rst", core_rst, 0);
    chk("ar_busy_grant", grant, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_core_rst", core_rst, 1);
    chk("ar_rsp_valid", rsp_valid, 0);
    do_reset();

`ifdef SHAKE_ARB_TIMEOUT_EN
    begin
      int pulses;
      pulses = 0;
      req = 4'b0100;
      @(posedge clk); #1 req = '0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (err_timeout) pulses++;
      end
      chk("tmo_pulses", pulses, 1);
      chk("tmo_grant", grant, 0);
      do_reset();
    end
`endif

    // Randomized traffic against the job-level model.
    m_own = -1; m_age = 0; m_rr = 0; m_idle = 0; m_done = 1'b0; m_err = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      req = 4'($urandom);
      rel = ($urandom_range(0, 5) == 0) ? 4'($urandom) : '0;
      req_valid = 4'($urandom);
      req_last = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      for (int i = 0; i < N; i++) begin
        req_data[i*DI +: DI] = {$urandom, $urandom};
        req_last_len[i*LW +: LW] = 7'($urandom_range(1, 64));
      end
      req_out_ready = 4'($urandom);
      core_in_ready = $urandom_range(0, 3) != 0;
      core_out_valid = 1'($urandom);
      core_data_out = {$urandom, $urandom};
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_step();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
